fft_pt_dispatch: RTL

//  Downstream of the FFT ring node. Accepts completed point groups: PDEPTH {src_node_id, fft_pt} entries,
//  one per butterfly partner. Queues groups and streams them one partner per beat, tagged by stage,
//  to the local FFT engine over valid/ready. Checks group consistency and point ordering.

---
 rtl/fft_pt_dispatch_if.sv | 27 ++
 rtl/fft_pt_dispatch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fft_pt_dispatch_if.sv
// Handshake bundle between the ring node (group side), the dispatcher and the FFT engine (beat side).
interface fft_pt_dispatch_if #(
  parameter int unsigned NNNODES = 32'd16
) ();
  localparam int unsigned PDEPTH = $clog2(NNNODES) - 1;
  localparam int unsigned SW     = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;

  logic                  grp_valid;
  logic                  grp_ready;
  logic [PDEPTH*64-1:0]  grp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SW-1:0]         out_stage;
  logic [31:0]           out_partner_id;
  logic [31:0]           out_fft_pt;
  logic                  out_last;

  modport master (
    output grp_valid, grp_data, out_ready,
    input  grp_ready, out_valid, out_stage, out_partner_id, out_fft_pt, out_last
  );

  modport slave (
    input  grp_valid, grp_data, out_ready,
    output grp_ready, out_valid, out_stage, out_partner_id, out_fft_pt, out_last
  );
endinterface

// File: rtl/fft_pt_dispatch.sv
// Point-group dispatcher: queues butterfly-partner groups from the ring node and streams them
// one partner per beat to the local FFT engine, flagging inconsistent or out-of-order groups.
module fft_pt_dispatch #(
  parameter int unsigned NNNODES = 32'd16,
  parameter int unsigned NODEID  = 32'd0,
  parameter int unsigned QDEPTH  = 32'd4
) (
  input  logic              clk,
  input  logic              rstn,
  fft_pt_dispatch_if.slave  bus,
  output logic [31:0]       grp_done_cnt,
  output logic [15:0]       drop_cnt,
  output logic              err_mismatch,
  output logic              err_order
);
  localparam int unsigned PDEPTH = $clog2(NNNODES) - 1;
  localparam int unsigned SW     = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;
  localparam int unsigned GW     = PDEPTH * 64;
  localparam int unsigned PW     = $clog2(QDEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(PDEPTH - 1);

  if (NNNODES < 4 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_param
    $error("fft_pt_dispatch node %0d: illegal NNNODES/QDEPTH", NODEID);
  end

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   mem_q [QDEPTH];
  logic [GW-1:0]   mem_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   work_q, work_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [31:0]     out_partner_q, out_partner_d;
  logic [31:0]     out_pt_q, out_pt_d;
  logic [31:0]     exp_pt_q, exp_pt_d;
  logic [31:0]     done_cnt_q, done_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            err_mis_q, err_mis_d;
  logic            err_ord_q, err_ord_d;

  logic            accept;
  logic            mismatch;
  logic            push;
  logic            pop;
  logic [63:0]     next_entry;

  function automatic logic [63:0] entry_at(input logic [GW-1:0] g, input logic [SW-1:0] idx);
    return g[64*int'(idx) +: 64];
  endfunction

  // Ready depends only on stored occupancy; a pop in the same cycle does not open a slot.
  assign bus.grp_ready = rstn & (count_q != CW'(QDEPTH));
  assign accept        = bus.grp_valid & bus.grp_ready;

  // Input side: consistency/order checks and FIFO bookkeeping.
  always_comb begin
    mismatch   = 1'b0;
    push       = 1'b0;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    exp_pt_d   = exp_pt_q;
    drop_cnt_d = drop_cnt_q;
    err_mis_d  = err_mis_q;
    err_ord_d  = err_ord_q;

    for (int i = 1; i < int'(PDEPTH); i++) begin
      if (bus.grp_data[64*i +: 32] != bus.grp_data[31:0]) mismatch = 1'b1;
    end

    if (accept) begin
      if (mismatch) begin
        err_mis_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        push = 1'b1;
        if (bus.grp_data[31:0] != exp_pt_q) err_ord_d = 1'b1;
        exp_pt_d = bus.grp_data[31:0] + 32'd1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = bus.grp_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Dispatch FSM: IDLE waits for a group, LOAD pops it, SEND streams one partner per beat.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    work_d        = work_q;
    stage_d       = stage_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_partner_d = out_partner_q;
    out_pt_d      = out_pt_q;
    done_cnt_d    = done_cnt_q;
    pop           = 1'b0;
    next_entry    = '0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        pop           = 1'b1;
        rd_ptr_d      = rd_ptr_q + PW'(1);
        work_d        = mem_q[rd_ptr_q];
        stage_d       = '0;
        out_valid_d   = 1'b1;
        out_partner_d = mem_q[rd_ptr_q][63:32];
        out_pt_d      = mem_q[rd_ptr_q][31:0];
        out_last_d    = (PDEPTH == 1);
        state_d       = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (stage_q == LAST_STAGE) begin
            done_cnt_d  = done_cnt_q + 32'd1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = (count_q != '0) ? LOAD : IDLE;
          end else begin
            stage_d       = stage_q + SW'(1);
            next_entry    = entry_at(work_q, stage_q + SW'(1));
            out_partner_d = next_entry[63:32];
            out_pt_d      = next_entry[31:0];
            out_last_d    = ((stage_q + SW'(1)) == LAST_STAGE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      work_q        <= '0;
      stage_q       <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_partner_q <= '0;
      out_pt_q      <= '0;
      exp_pt_q      <= 32'd1;
      done_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      err_mis_q     <= 1'b0;
      err_ord_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      work_q        <= work_d;
      stage_q       <= stage_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_partner_q <= out_partner_d;
      out_pt_q      <= out_pt_d;
      exp_pt_q      <= exp_pt_d;
      done_cnt_q    <= done_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      err_mis_q     <= err_mis_d;
      err_ord_q     <= err_ord_d;
    end
  end

  // Storage array needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_last       = out_last_q;
  assign bus.out_stage      = stage_q;
  assign bus.out_partner_id = out_partner_q;
  assign bus.out_fft_pt     = out_pt_q;
  assign grp_done_cnt       = done_cnt_q;
  assign drop_cnt           = drop_cnt_q;
  assign err_mismatch       = err_mis_q;
  assign err_order          = err_ord_q;
endmodule
